// File: rtl/trigger_crossbar_matrix.sv
// trigger_crossbar_matrix: routes synchronised/raw trigger inputs to outputs with per-output mode, edge statistics and activity LEDs
module trigger_crossbar_matrix #(
    parameter int NUM_IN = 12,
    parameter int NUM_OUT = 12,
    parameter int PULSE_WIDTH = 16,
    parameter int LED_HOLD = 6250000,
    parameter int CNT_WIDTH = 32,
    localparam int SW = $clog2(NUM_IN),
    localparam int OW = $clog2(NUM_OUT),
    localparam int CW = SW + 2 + PULSE_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_IN-1:0]    trig_in,
    output logic [NUM_OUT-1:0]   trig_out,
    input  logic                 cfg_wr_en,
    input  logic [OW-1:0]        cfg_addr,
    input  logic [CW-1:0]        cfg_wr_data,
    output logic [CW-1:0]        cfg_rd_data,
    input  logic [SW-1:0]        stat_sel,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] stat_count,
    output logic [NUM_IN-1:0]    trig_in_led,
    output logic [NUM_OUT-1:0]   trig_out_led
);
    localparam int LW = $clog2(LED_HOLD + 1);
    localparam logic [CW-1:0] CFG_RST = {PULSE_WIDTH'(1), 2'b00, SW'(0)};

    logic [NUM_IN-1:0] s1, s2, p, rise_in, any_in;
    logic [NUM_OUT-1:0] os1, os2, op, any_out;
    logic [CW-1:0] cfg [NUM_OUT];
    logic [CNT_WIDTH-1:0] ecnt [NUM_IN];
    logic cfg_wr_ok;

    assign rise_in = s2 & ~p;
    assign any_in = s2 ^ p;
    assign any_out = os2 ^ op;
    assign cfg_wr_ok = cfg_wr_en && int'(cfg_addr) < NUM_OUT;

    // Input synchronisers with history flop, plus resampling of the (partly combinational) outputs for the LEDs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            p <= '0;
            os1 <= '0;
            os2 <= '0;
            op <= '0;
        end else begin
            s1 <= trig_in;
            s2 <= s1;
            p <= s2;
            os1 <= trig_out;
            os2 <= os1;
            op <= os2;
        end
    end

    // Configuration table; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) cfg[k] <= CFG_RST;
        end else if (cfg_wr_ok) begin
            cfg[cfg_addr] <= cfg_wr_data;
        end
    end

    // Registered readback; a write in the same cycle is forwarded so the new value shows immediately after
    always_ff @(posedge clk) begin
        if (!rst_n) cfg_rd_data <= '0;
        else cfg_rd_data <= (int'(cfg_addr) >= NUM_OUT) ? '0 : cfg_wr_ok ? cfg_wr_data : cfg[cfg_addr];
    end

    // Saturating rising-edge counters; a clear beats a coincident edge
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (!rst_n || (stat_clr && int'(stat_sel) == k)) ecnt[k] <= '0;
            else if (rise_in[k] && ~&ecnt[k]) ecnt[k] <= ecnt[k] + 1'b1;
        end
    end

    // Registered counter readback, zero for nonexistent inputs
    always_ff @(posedge clk) begin
        if (!rst_n) stat_count <= '0;
        else stat_count <= (int'(stat_sel) < NUM_IN) ? ecnt[stat_sel] : '0;
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in_led
        logic [LW-1:0] hold;
        // Input LED hold-off timer, reloaded on every edge
        always_ff @(posedge clk) begin
            if (!rst_n) hold <= '0;
            else if (any_in[i]) hold <= LW'(LED_HOLD);
            else if (hold != '0) hold <= hold - 1'b1;
        end
        assign trig_in_led[i] = hold != '0;
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        typedef enum logic {IDLE, HIGH} state_t;
        state_t state;
        logic [PULSE_WIDTH-1:0] cnt, len;
        logic [SW-1:0] src;
        logic [1:0] mode;
        logic valid, raw, rise, wr, pq;
        logic [LW-1:0] hold;

        assign {len, mode, src} = cfg[j];
        assign valid = int'(src) < NUM_IN;
        assign raw = valid && trig_in[src];
        assign rise = valid && mode == 2'd3 && rise_in[src];
        assign wr = cfg_wr_ok && int'(cfg_addr) == j;
        assign trig_out[j] = valid && (mode == 2'd1 ? raw : mode == 2'd2 ? ~raw : mode == 2'd3 && pq);

        // Retriggerable pulse stretcher; a config write to this output aborts any pulse in flight
        always_ff @(posedge clk) begin
            if (!rst_n || wr) begin
                state <= IDLE;
                cnt <= '0;
                pq <= 1'b0;
            end else begin
                pq <= state == HIGH;
                if (rise) begin
                    state <= HIGH;
                    cnt <= (len == '0) ? PULSE_WIDTH'(1) : len;
                end else if (state == HIGH) begin
                    state <= (cnt <= PULSE_WIDTH'(1)) ? IDLE : HIGH;
                    cnt <= cnt - 1'b1;
                end
            end
        end

        // Output LED hold-off timer fed by the resampled output
        always_ff @(posedge clk) begin
            if (!rst_n) hold <= '0;
            else if (any_out[j]) hold <= LW'(LED_HOLD);
            else if (hold != '0) hold <= hold - 1'b1;
        end
        assign trig_out_led[j] = hold != '0;
    end
endmodule

// File: doc/trigger_crossbar_matrix.md
Name: trigger_crossbar_matrix

Overview:
- Parametrised successor to the fixed 12x12 trigger crossbar.
- Routes NUM_IN asynchronous trigger inputs to NUM_OUT outputs. Each output has its own source select and mode: off, pass, invert, or retriggerable pulse-stretch.
- Also provides per-input rising-edge statistics counters and LED activity stretchers for the front panel.
- Sits between the trigger input buffers and the output drivers; configured by the management register bridge.

Parameters:
- NUM_IN, 12, number of trigger inputs.
- NUM_OUT, 12, number of trigger outputs.
- PULSE_WIDTH, 16, bit width of the pulse-stretch length field.
- LED_HOLD, 6250000, cycles an LED stays lit after activity (50 ms at 125 MHz).
- CNT_WIDTH, 32, width of the per-input edge counters.
- Derived (not overridable): SW=$clog2(NUM_IN), OW=$clog2(NUM_OUT), CW=SW+2+PULSE_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- trig_in  in  NUM_IN  asynchronous trigger inputs.
- trig_out  out  NUM_OUT  trigger outputs.
- cfg_wr_en  in  1  config write strobe.
- cfg_addr  in  OW  output index for write and readback.
- cfg_wr_data  in  CW  {len[PULSE_WIDTH-1:0], mode[1:0], src[SW-1:0]}.
- cfg_rd_data  out  CW  config of output cfg_addr, registered.
- stat_sel  in  SW  input index for counter readback/clear.
- stat_clr  in  1  clear counter stat_sel.
- stat_count  out  CNT_WIDTH  edge count of input stat_sel, registered.
- trig_in_led  out  NUM_IN  input activity LEDs.
- trig_out_led  out  NUM_OUT  output activity LEDs.

Behaviour:
- Reset (rst_n low at a clk edge): every config entry becomes src=0, mode=OFF, len=1. All pulse counters, edge counters and LED counters are cleared. Synchronizer flops are cleared. All registered outputs are 0, and trig_out=0 because mode is OFF.
- Reset mid-pulse aborts the pulse; trig_out drops as soon as rst_n is sampled low.
- Synchronizer: every trig_in bit passes through a 2-FF synchronizer (s1, s2) plus a history flop p. Rising edge is s2&~p; any edge is s2^p.
- Mode encoding:
  - 0 OFF: trig_out[j]=0.
  - 1 PASS: trig_out[j]=trig_in[src], combinational from the raw input, zero latency.
  - 2 INV: trig_out[j]=~trig_in[src], combinational.
  - 3 PULSE: trig_out[j] is registered from the pulse FSM.
- src >= NUM_IN: output forced 0 in all modes.
- PULSE FSM per output, states IDLE and HIGH:
  - IDLE -> HIGH on rising edge of synced src. Counter loads len; len=0 is treated as 1. trig_out goes high on the following clk edge.
  - Input rise meeting setup before edge k gives trig_out high after edge k+3. It stays high for exactly len cycles.
  - A rising edge while in HIGH reloads the counter with len (retrigger extends the pulse); the output does not glitch low.
  - HIGH -> IDLE when the counter reaches 1 with no new edge.
- Config write: on a cfg_wr_en edge with cfg_addr < NUM_OUT, the entry updates and that output's pulse FSM is forced to IDLE with its counter cleared. The new mode takes effect the next cycle.
  - cfg_addr >= NUM_OUT: write ignored.
  - cfg_rd_data is registered, 1-cycle latency from cfg_addr, and reflects a same-cycle write on the following cycle. Out-of-range address reads 0.
- Edge counters: increment on each synced rising edge of their input and saturate at all-ones (no wrap).
  - stat_clr sets counter stat_sel to 0. Clear wins over a simultaneous edge on that input, so the edge is not counted.
  - stat_count is registered, 1-cycle latency. stat_sel >= NUM_IN reads 0.
- LEDs:
  - trig_in_led[i]: any synced edge loads the hold counter with LED_HOLD and sets the LED. The LED stays 1 while the counter is nonzero. Further edges reload the counter.
  - trig_out_led[j]: same scheme, driven from trig_out[j] re-sampled through its own 2-FF synchronizer, because PASS/INV outputs are combinational.

Test Plan:
- Reset: hold rst_n low 4 cycles while toggling trig_in -> trig_out=0, all LEDs 0, stat_count=0, cfg_rd_data={len=1,mode=0,src=0}.
- PASS/INV: set out3 to src=5 PASS and out4 to src=5 INV; toggle trig_in[5] -> out3 follows with no clock delay and out4 is its complement. Set src=13 on out3 -> out3 held 0.
- PULSE: set out0 to src=2, mode=3, len=10; apply a 1-cycle rise on trig_in[2] -> out0 high after the 3rd edge for exactly 10 cycles. Retrigger at pulse cycle 6 -> total high 16 cycles, no gap. len=0 -> 1-cycle pulse.
- Config mid-pulse: rewrite out0 to OFF at pulse cycle 4 -> out0 low the next cycle; later input edges give no pulse.
- Counters: 7 rising edges on trig_in[1] -> stat_count=7. stat_clr coincident with the 8th edge -> 0. Preload near max via a short CNT_WIDTH=4 build with 20 edges -> reads 15.
- LEDs with LED_HOLD=8: a single edge on trig_in[0] -> trig_in_led[0] high 8 cycles. A second edge at cycle 5 -> extends to cycle 13. A PASS output toggle lights trig_out_led after 2-3 cycles.
